// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD counter controller.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_START = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic nibble_ok(input logic [3:0] n);
    return n <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: clear, parallel load, or single up/down step with 9<->0 wrap.
module bcd_digit_cell
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      if (up) q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      else    q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == 4'd0);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Command-driven controller for a cascaded BCD up/down counter with prescaled
// stepping, validated loads and terminal-count detection.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 10,
  parameter int unsigned AUTO_STOP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [4*NUM_DIGITS-1:0] cmd_data,
  input  logic                    dir_up,
  output logic [4*NUM_DIGITS-1:0] count_out,
  output logic                    busy,
  output logic                    tc_pulse,
  output logic                    err_pulse
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  state_e                    state;
  cmd_op_e                   op;
  logic [PW-1:0]             presc;
  logic                      dir_q;
  logic [4*NUM_DIGITS-1:0]   ld_data;
  logic                      accept, tick, terminal, step, ld_ok, clr, ld;
  logic [NUM_DIGITS-1:0]     at_max, at_min, en;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state != S_CHECK);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state == S_RUN) && (presc == P_LAST);
  assign terminal  = dir_q ? (&at_max) : (&at_min);
  // An accepted command discards a coincident tick; with auto-stop the
  // terminal tick freezes the count instead of wrapping it.
  assign step      = tick && !accept && !(terminal && (AUTO_STOP != 0));
  assign clr       = accept && (op == CMD_CLEAR);
  assign ld        = (state == S_CHECK) && ld_ok;

  always_comb begin
    ld_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!nibble_ok(ld_data[4*i +: 4])) ld_ok = 1'b0;
    end
  end

  // Ripple enable: a digit steps only when every lower digit is at its wrap value.
  always_comb begin
    logic run;
    run = step;
    en  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      en[i] = run;
      run   = run && (dir_q ? at_max[i] : at_min[i]);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .ld     (ld),
      .ld_val (ld_data[4*g +: 4]),
      .en     (en[g]),
      .up     (dir_q),
      .q      (count_out[4*g +: 4]),
      .at_max (at_max[g]),
      .at_min (at_min[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      presc     <= '0;
      dir_q     <= 1'b1;
      ld_data   <= '0;
      busy      <= 1'b0;
      tc_pulse  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      tc_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      if (accept) begin
        case (op)
          CMD_CLEAR: begin
            state <= S_IDLE;
            presc <= '0;
            busy  <= 1'b0;
          end
          CMD_LOAD: begin
            ld_data <= cmd_data;
            state   <= S_CHECK;
            presc   <= '0;
            busy    <= 1'b0;
          end
          CMD_START: begin
            dir_q <= dir_up;
            presc <= '0;
            state <= S_RUN;
            busy  <= 1'b1;
          end
          default: begin
            if (state == S_RUN) begin
              state <= S_IDLE;
              presc <= '0;
              busy  <= 1'b0;
            end
          end
        endcase
      end else begin
        case (state)
          S_CHECK: begin
            err_pulse <= !ld_ok;
            state     <= S_IDLE;
          end
          S_RUN: begin
            if (tick) begin
              presc <= '0;
              if (terminal) begin
                tc_pulse <= 1'b1;
                if (AUTO_STOP != 0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                end
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench: decimal reference model predicts each cycle's outputs.
module tb_bcd_count_ctrl;

  localparam int ND = 2;
  localparam int PS = 3;
  localparam int AS = 1;
  localparam int MODV = 100;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, dir_up, busy, tc_pulse, err_pulse;
  logic [1:0]    cmd_op;
  logic [4*ND-1:0] cmd_data, count_out;

  bcd_count_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .AUTO_STOP(AS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .dir_up    (dir_up),
    .count_out (count_out),
    .busy      (busy),
    .tc_pulse  (tc_pulse),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       bsy;
    logic       tc;
    logic       err;
    logic       rdy;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: count held as a plain decimal integer.
  int   m_mode  = 0;   // 0 idle, 1 check, 2 run, 3 done
  int   m_count = 0;
  int   m_phase = 0;
  bit   m_dir   = 1'b1;
  logic [7:0] m_pend = '0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [1:0] op,
                            input logic [7:0] d, input bit du, output exp_t e);
    bit tc, err, acc, term;
    tc = 0; err = 0;
    if (r) begin
      m_mode = 0; m_count = 0; m_phase = 0; m_dir = 1;
    end else begin
      acc = v && (m_mode != 1);
      if (acc) begin
        case (op)
          2'b00: begin m_count = 0; m_mode = 0; m_phase = 0; end
          2'b01: begin m_pend = d; m_mode = 1; end
          2'b10: begin m_dir = du; m_phase = 0; m_mode = 2; end
          default: if (m_mode == 2) begin m_mode = 0; m_phase = 0; end
        endcase
      end else if (m_mode == 1) begin
        if (m_pend[7:4] <= 4'd9 && m_pend[3:0] <= 4'd9)
          m_count = int'(m_pend[7:4]) * 10 + int'(m_pend[3:0]);
        else
          err = 1;
        m_mode = 0;
      end else if (m_mode == 2) begin
        if (m_phase == PS - 1) begin
          m_phase = 0;
          term = m_dir ? (m_count == MODV - 1) : (m_count == 0);
          if (term) tc = 1;
          if (term && AS != 0) m_mode = 3;
          else m_count = m_dir ? (m_count + 1) % MODV : (m_count + MODV - 1) % MODV;
        end else begin
          m_phase++;
        end
      end
    end
    e.cnt = to_bcd(m_count);
    e.bsy = (m_mode == 2);
    e.tc  = tc;
    e.err = err;
    e.rdy = (m_mode != 1);
  endtask

  task automatic drive(input bit r, input bit v, input logic [1:0] op,
                       input logic [7:0] d, input bit du);
    exp_t e;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = d; dir_up = du;
    model_step(r, v, op, d, du, e);
    cyc++;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'b00, 8'h00, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count_out", 32'(count_out), 32'(e.cnt), e.cyc);
        chk("busy",      32'(busy),      32'(e.bsy), e.cyc);
        chk("tc_pulse",  32'(tc_pulse),  32'(e.tc),  e.cyc);
        chk("err_pulse", 32'(err_pulse), 32'(e.err), e.cyc);
        chk("cmd_ready", 32'(cmd_ready), 32'(e.rdy), e.cyc);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d;
    int unsigned sel;
    rst = 1; cmd_valid = 0; cmd_op = 2'b00; cmd_data = '0; dir_up = 1;
    drive(1, 0, 2'b00, 8'h00, 1'b1);
    drive(1, 0, 2'b00, 8'h00, 1'b1);
    drive(0, 1, 2'b01, 8'h47, 1'b1); idle(3);          // valid load
    drive(0, 1, 2'b01, 8'h4A, 1'b1); idle(3);          // rejected load
    drive(0, 1, 2'b01, 8'h08, 1'b1); idle(2);
    drive(0, 1, 2'b10, 8'h00, 1'b1); idle(8);          // carry 09 -> 10
    drive(0, 1, 2'b01, 8'h98, 1'b1); idle(2);
    drive(0, 1, 2'b10, 8'h00, 1'b1); idle(10);         // terminal, auto-stop
    drive(0, 1, 2'b01, 8'h10, 1'b1); idle(2);
    drive(0, 1, 2'b10, 8'h00, 1'b0); idle(5);          // borrow 10 -> 09
    drive(0, 1, 2'b11, 8'h00, 1'b1); idle(4);          // STOP on a tick cycle
    drive(0, 1, 2'b01, 8'h55, 1'b1); idle(2);
    drive(0, 1, 2'b10, 8'h00, 1'b1); idle(1);
    drive(1, 0, 2'b00, 8'h00, 1'b1); idle(3);          // reset mid-prescale
    drive(0, 1, 2'b01, 8'h01, 1'b1); idle(2);
    drive(0, 1, 2'b10, 8'h00, 1'b0); idle(9);          // down to terminal 00

    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       d = to_bcd(int'($urandom_range(0, 99)));
      else if (sel < 8) begin
        case ($urandom_range(0, 5))
          0: d = 8'h98; 1: d = 8'h99; 2: d = 8'h00;
          3: d = 8'h01; 4: d = 8'h09; default: d = 8'h90;
        endcase
      end else           d = 8'($urandom_range(0, 255));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
            2'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)));
    end
    idle(2);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
